// File: rtl/ecc29_pkg.sv
// Shared constants and types for the 23-to-29 BCH read-path monitor.
// The log entry carries a fixed-width address field; users truncate to their own ADDR_W.
package ecc29_pkg;

   localparam int DATA_W     = 23;
   localparam int CW_W       = 29;
   localparam int LOC_W      = 5;
   localparam int LOG_ADDR_W = 32;

   typedef enum logic [1:0] {
      LOG_EMPTY = 2'd0,
      LOG_CE    = 2'd1,
      LOG_UE    = 2'd2
   } log_state_e;

   typedef struct packed {
      logic                  typ;
      logic [LOG_ADDR_W-1:0] addr;
      logic [LOC_W-1:0]      loc;
   } log_entry_t;

endpackage

// File: rtl/ecc29_sat_cnt.sv
// Saturating up-counter with synchronous clear; a clear coinciding with an
// increment leaves the count at 1 so that event is not lost.
module ecc29_sat_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= inc ? W'(1) : '0;
      end else if (inc && (r_cnt != '1)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign cnt = r_cnt;

endmodule

// File: rtl/ecc29_rd_monitor.sv
// Read-path stage after the BCH decoder: one-deep valid/ready register, error
// counters, first-error log and scrub interrupt. Optional: ECC29_MON_CE_THRESH_IRQ_EN.
module ecc29_rd_monitor
   import ecc29_pkg::*;
#(
   parameter int ADDR_W    = 16,
   parameter int CNT_W     = 8,
   parameter int CE_THRESH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_err_correct,
   input  logic              in_err_uncorrect,
   input  logic [LOC_W-1:0]  in_err_loc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_uncorr,
   output logic [CNT_W-1:0]  ce_cnt,
   output logic [CNT_W-1:0]  ue_cnt,
   input  logic              cnt_clr,
   output logic              log_valid,
   output logic              log_type,
   output logic [ADDR_W-1:0] log_addr,
   output logic [LOC_W-1:0]  log_loc,
   input  logic              log_clr,
   output logic              irq
);

`ifdef ECC29_MON_CE_THRESH_IRQ_EN
   localparam bit THRESH_IRQ_EN = 1'b1;
`else
   localparam bit THRESH_IRQ_EN = 1'b0;
`endif

   localparam logic [CNT_W:0] CE_THRESH_EXT = (CNT_W+1)'(CE_THRESH);

   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic [ADDR_W-1:0] r_out_addr;
   logic              r_out_uncorr;
   log_state_e        r_log_state;
   log_state_e        w_log_state_next;
   log_entry_t        r_log_entry;
   log_entry_t        w_log_entry_next;
   logic              w_accept;
   logic              w_ce_evt;
   logic              w_ue_evt;
   log_state_e        w_log_base;

   assign in_ready = !r_out_valid | out_ready;
   assign w_accept = in_valid & in_ready;
   // Both flags set means the decoder gave up: the word is poison, not a CE.
   assign w_ue_evt = w_accept & in_err_uncorrect;
   assign w_ce_evt = w_accept & in_err_correct & !in_err_uncorrect;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_addr   <= '0;
         r_out_uncorr <= 1'b0;
      end else if (w_accept) begin
         r_out_valid  <= 1'b1;
         r_out_data   <= in_data;
         r_out_addr   <= in_addr;
         r_out_uncorr <= in_err_uncorrect;
      end else if (out_ready) begin
         r_out_valid  <= 1'b0;
      end
   end

   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign out_addr   = r_out_addr;
   assign out_uncorr = r_out_uncorr;

   ecc29_sat_cnt #(.W(CNT_W)) u_ce_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (w_ce_evt),
      .cnt (ce_cnt)
   );

   ecc29_sat_cnt #(.W(CNT_W)) u_ue_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (w_ue_evt),
      .cnt (ue_cnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_log_state <= LOG_EMPTY;
         r_log_entry <= '0;
      end else begin
         r_log_state <= w_log_state_next;
         r_log_entry <= w_log_entry_next;
      end
   end

   // Clear is applied first so an event in the same cycle lands in a fresh log.
   always_comb begin
      w_log_state_next = r_log_state;
      w_log_entry_next = r_log_entry;
      w_log_base       = log_clr ? LOG_EMPTY : r_log_state;
      if (log_clr) begin
         w_log_state_next = LOG_EMPTY;
         w_log_entry_next = '0;
      end
      if (w_ue_evt && (w_log_base != LOG_UE)) begin
         w_log_state_next      = LOG_UE;
         w_log_entry_next.typ  = 1'b1;
         w_log_entry_next.addr = LOG_ADDR_W'(in_addr);
         w_log_entry_next.loc  = '0;
      end else if (w_ce_evt && (w_log_base == LOG_EMPTY)) begin
         w_log_state_next      = LOG_CE;
         w_log_entry_next.typ  = 1'b0;
         w_log_entry_next.addr = LOG_ADDR_W'(in_addr);
         w_log_entry_next.loc  = in_err_loc;
      end
   end

   assign log_valid = (r_log_state != LOG_EMPTY);
   assign log_type  = r_log_entry.typ;
   assign log_addr  = ADDR_W'(r_log_entry.addr);
   assign log_loc   = r_log_entry.loc;

   assign irq = THRESH_IRQ_EN
              ? ((log_type & log_valid) | ({1'b0, ce_cnt} >= CE_THRESH_EXT))
              : log_valid;

endmodule

// File: tb/tb_ecc29_rd_monitor.sv
// Directed bench for ecc29_rd_monitor: output words checked through a scoreboard
// queue, counters/log/irq against a small reference model.
module tb_ecc29_rd_monitor;

`ifdef ECC29_MON_CE_THRESH_IRQ_EN
   localparam int  TB_CNT_W  = 3;
   localparam bit  TB_THR_EN = 1'b1;
`else
   localparam int  TB_CNT_W  = 2;
   localparam bit  TB_THR_EN = 1'b0;
`endif
   localparam int TB_THRESH = 4;
   localparam int MAXC      = (1 << TB_CNT_W) - 1;

   logic                clk = 1'b0;
   logic                rst;
   logic                in_valid;
   logic                in_ready;
   logic [15:0]         in_addr;
   logic [22:0]         in_data;
   logic                in_err_correct;
   logic                in_err_uncorrect;
   logic [4:0]          in_err_loc;
   logic                out_valid;
   logic                out_ready;
   logic [22:0]         out_data;
   logic [15:0]         out_addr;
   logic                out_uncorr;
   logic [TB_CNT_W-1:0] ce_cnt;
   logic [TB_CNT_W-1:0] ue_cnt;
   logic                cnt_clr;
   logic                log_valid;
   logic                log_type;
   logic [15:0]         log_addr;
   logic [4:0]          log_loc;
   logic                log_clr;
   logic                irq;

   ecc29_rd_monitor #(.ADDR_W(16), .CNT_W(TB_CNT_W), .CE_THRESH(TB_THRESH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .in_data(in_data), .in_err_correct(in_err_correct),
      .in_err_uncorrect(in_err_uncorrect), .in_err_loc(in_err_loc),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_addr(out_addr), .out_uncorr(out_uncorr), .ce_cnt(ce_cnt), .ue_cnt(ue_cnt),
      .cnt_clr(cnt_clr), .log_valid(log_valid), .log_type(log_type),
      .log_addr(log_addr), .log_loc(log_loc), .log_clr(log_clr), .irq(irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [22:0] d;
      logic [15:0] a;
      logic        u;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // reference model state
   logic        m_ov;
   int          m_ce, m_ue;
   int          m_log;          // 0 empty, 1 CE, 2 UE
   logic [15:0] m_laddr;
   logic [4:0]  m_lloc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_ov = 1'b0; m_ce = 0; m_ue = 0; m_log = 0; m_laddr = '0; m_lloc = '0;
   endtask

   function automatic logic exp_irq();
      if (TB_THR_EN) return (m_log == 2) || (m_ce >= TB_THRESH);
      return m_log != 0;
   endfunction

   task automatic check_state(input string ctx);
      check({ctx, ".out_valid"}, 32'(out_valid), 32'(m_ov));
      check({ctx, ".ce_cnt"},    32'(ce_cnt),    32'(m_ce));
      check({ctx, ".ue_cnt"},    32'(ue_cnt),    32'(m_ue));
      check({ctx, ".log_valid"}, 32'(log_valid), 32'(m_log != 0));
      if (m_log != 0) begin
         check({ctx, ".log_type"}, 32'(log_type), 32'(m_log == 2));
         check({ctx, ".log_addr"}, 32'(log_addr), 32'(m_laddr));
         check({ctx, ".log_loc"},  32'(log_loc),  32'(m_lloc));
      end
      check({ctx, ".irq"}, 32'(irq), 32'(exp_irq()));
   endtask

   function automatic int cnt_next(input int c, input logic evt, input logic clr);
      if (clr) return evt ? 1 : 0;
      if (evt && c < MAXC) return c + 1;
      return c;
   endfunction

   // One clock: drive, check handshake/scoreboard before the edge, update model, check after.
   task automatic step(input string tag, input logic iv, input logic [15:0] a,
                       input logic [22:0] d, input logic ce, input logic ue,
                       input logic [4:0] loc, input logic ordy,
                       input logic cclr, input logic lclr);
      logic  rdy, acc, ce_e, ue_e;
      int    base;
      exp_t  e;
      in_valid = iv; in_addr = a; in_data = d; in_err_correct = ce;
      in_err_uncorrect = ue; in_err_loc = loc; out_ready = ordy;
      cnt_clr = cclr; log_clr = lclr;
      #1;
      rdy = !m_ov || ordy;
      acc = iv && rdy;
      check({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
      if (m_ov) begin
         check({tag, ".q_nonempty"}, 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) begin
            e = q[0];
            check({tag, ".out_data"},   32'(out_data),   32'(e.d));
            check({tag, ".out_addr"},   32'(out_addr),   32'(e.a));
            check({tag, ".out_uncorr"}, 32'(out_uncorr), 32'(e.u));
            if (ordy) void'(q.pop_front());
         end
      end
      if (acc) begin
         e.d = d; e.a = a; e.u = ue;
         q.push_back(e);
      end
      ue_e = acc && ue;
      ce_e = acc && ce && !ue;
      m_ce = cnt_next(m_ce, ce_e, cclr);
      m_ue = cnt_next(m_ue, ue_e, cclr);
      base = lclr ? 0 : m_log;
      if (lclr) m_log = 0;
      if (ue_e && base != 2) begin
         m_log = 2; m_laddr = a; m_lloc = '0;
      end else if (ce_e && base == 0) begin
         m_log = 1; m_laddr = a; m_lloc = loc;
      end
      m_ov = acc ? 1'b1 : (ordy ? 1'b0 : m_ov);
      @(posedge clk);
      #1;
      check_state(tag);
      $display("step %-10s iv=%0b addr=%h ce=%0b ue=%0b ordy=%0b acc=%0b ce_cnt=%0d ue_cnt=%0d log=%0d irq=%0b",
               tag, iv, a, ce, ue, ordy, acc, ce_cnt, ue_cnt, log_valid, irq);
   endtask

   task automatic idle(input string tag);
      step(tag, 1'b0, 16'h0, 23'h0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 0; in_addr = '0; in_data = '0; in_err_correct = 0;
      in_err_uncorrect = 0; in_err_loc = '0; out_ready = 1; cnt_clr = 0; log_clr = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst.in_ready", 32'(in_ready), 32'd1);
      check_state("rst");
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Clean back-to-back stream
      for (int i = 0; i < 4; i++)
         step("clean", 1'b1, 16'h10 + 16'(i), 23'h123456 + 23'(i), 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
      idle("drain");
      idle("drain");

      // Backpressure with correctable words held on the input
      step("bp_a", 1'b1, 16'h30, 23'h0AAAAA, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         step("bp_hold", 1'b1, 16'h31, 23'h055555, 1'b1, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0);
      step("bp_rel", 1'b1, 16'h31, 23'h055555, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0);
      idle("drain");
      step("clr", 1'b0, 16'h0, 23'h0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);

      // CE, CE, UE sequence
      step("ce1", 1'b1, 16'h20, 23'h000111, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
      step("ce2", 1'b1, 16'h21, 23'h000222, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
      step("ue1", 1'b1, 16'h22, 23'h000333, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
      idle("drain");

      // Both flags count as UE; out-of-range location logged verbatim
      step("clr", 1'b0, 16'h0, 23'h0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
      step("ce_loc30", 1'b1, 16'h40, 23'h004444, 1'b1, 1'b0, 5'd30, 1'b1, 1'b0, 1'b0);
      step("both", 1'b1, 16'h41, 23'h005555, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
      step("ue_sticky", 1'b1, 16'h42, 23'h006666, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
      idle("drain");

      // Saturation, then clear coinciding with an event
      step("clr", 1'b0, 16'h0, 23'h0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < MAXC + 2; i++)
         step("sat", 1'b1, 16'h50 + 16'(i), 23'h7F0000 + 23'(i), 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
      step("clr_ce", 1'b1, 16'h5F, 23'h7F00FF, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);

      // log_clr racing a UE event, then clear alone
      step("lclr_ue", 1'b1, 16'h60, 23'h060606, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1);
      step("lclr", 1'b0, 16'h0, 23'h0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);

      // Threshold ramp (irq expectation depends on the build)
      step("clr", 1'b0, 16'h0, 23'h0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++)
         step("thr_ce", 1'b1, 16'h70 + 16'(i), 23'h070000 + 23'(i), 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
      step("thr_ue", 1'b1, 16'h74, 23'h070074, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);

      // Asynchronous reset with a word held under backpressure
      step("pre_rst", 1'b1, 16'h80, 23'h080808, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0);
      #3 rst = 1'b1;
      #1;
      model_reset();
      check("arst.in_ready", 32'(in_ready), 32'd1);
      check_state("arst");
      in_valid = 1'b0;
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      step("post_rst", 1'b1, 16'h90, 23'h090909, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
      idle("drain");
      check("final.q_empty", 32'(q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
